// File: rtl/frame_receiver_if.sv
// Bundle of serial lane input and receiver outputs for frame_receiver.
// The receiver connects through the slave modport; the source side uses master.
interface frame_receiver_if;
    logic [2:0]  in_data;
    logic [23:0] out_data;
    logic [2:0]  out_valid;
    logic        sync_err;
    logic        hdr_err;
    logic [15:0] frame_cnt;
    logic        busy;

    modport master (
        output in_data,
        input  out_data, out_valid, sync_err, hdr_err, frame_cnt, busy
    );

    modport slave (
        input  in_data,
        output out_data, out_valid, sync_err, hdr_err, frame_cnt, busy
    );
endinterface

// File: rtl/frame_receiver.sv
// Serial frame receiver: 2 bits per slot, header byte + payload byte per frame,
// payload routed to one of three channel lanes selected by the header.
//
// state | meaning
// HUNT  | idle, waiting for a frame marker
// HDR   | assembling header byte (slots 1..3 after the marker slot)
// PAY   | assembling payload byte for the latched channel
module frame_receiver #(
    parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
    input  logic             clk,
    input  logic             arst,
    frame_receiver_if.slave  bus
);

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] PAY  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  slot_q, slot_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  chan_q, chan_d;
    logic [23:0] out_data_q, out_data_d;
    logic [2:0]  out_valid_q, out_valid_d;
    logic        sync_err_q, sync_err_d;
    logic        hdr_err_q, hdr_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        busy_q, busy_d;

    logic        marker;
    logic [1:0]  pair;
    logic [7:0]  byte_nxt;
    logic        hdr_ok;

    assign marker   = bus.in_data[2];
    assign pair     = bus.in_data[1:0];
    assign byte_nxt = {shift_q[5:0], pair};
    assign hdr_ok   = (byte_nxt[7:4] == SYNC_NIBBLE) && (byte_nxt[3:2] == 2'b00)
                      && (byte_nxt[1:0] != 2'd3);

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shift_d     = shift_q;
        chan_d      = chan_q;
        out_data_d  = out_data_q;
        out_valid_d = 3'b000;
        sync_err_d  = 1'b0;
        hdr_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            HUNT: begin
                if (marker) begin
                    state_d = HDR;
                    slot_d  = 2'd1;
                    shift_d = {6'b0, pair};
                end
            end
            HDR, PAY: begin
                if (marker) begin
                    // A marker anywhere inside a frame restarts it from this slot.
                    sync_err_d = 1'b1;
                    state_d    = HDR;
                    slot_d     = 2'd1;
                    shift_d    = {6'b0, pair};
                end else if (slot_q != 2'd3) begin
                    slot_d  = slot_q + 2'd1;
                    shift_d = byte_nxt;
                end else if (state_q == HDR) begin
                    shift_d = byte_nxt;
                    slot_d  = 2'd0;
                    if (hdr_ok) begin
                        chan_d  = byte_nxt[1:0];
                        state_d = PAY;
                    end else begin
                        hdr_err_d = 1'b1;
                        state_d   = HUNT;
                    end
                end else begin
                    shift_d     = byte_nxt;
                    slot_d      = 2'd0;
                    state_d     = HUNT;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    case (chan_q)
                        2'd0: begin
                            out_data_d[7:0] = byte_nxt;
                            out_valid_d     = 3'b001;
                        end
                        2'd1: begin
                            out_data_d[15:8] = byte_nxt;
                            out_valid_d      = 3'b010;
                        end
                        2'd2: begin
                            out_data_d[23:16] = byte_nxt;
                            out_valid_d       = 3'b100;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                state_d = HUNT;
                slot_d  = 2'd0;
            end
        endcase

        busy_d = (state_d != HUNT);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            shift_q     <= 8'h00;
            chan_q      <= 2'd0;
            out_data_q  <= 24'h0;
            out_valid_q <= 3'b000;
            sync_err_q  <= 1'b0;
            hdr_err_q   <= 1'b0;
            frame_cnt_q <= 16'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shift_q     <= shift_d;
            chan_q      <= chan_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            hdr_err_q   <= hdr_err_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.hdr_err   = hdr_err_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: good frames, back-to-back, header rejects,
// marker resync, mid-frame reset and frame counter wrap.
module tb_frame_receiver;

    logic clk;
    logic arst;
    int   n_checks;
    int   n_pass;

    frame_receiver_if bus ();

    frame_receiver #(.SYNC_NIBBLE(4'hA)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one slot, let the rising edge sample it, then settle 1 time unit.
    task automatic slot(input logic m, input logic [1:0] p);
        bus.in_data = {m, p};
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic m0, input logic [7:0] b);
        logic [7:0] sh;
        sh = b;
        for (int k = 0; k < 4; k++) begin
            slot((k == 0) ? m0 : 1'b0, sh[7:6]);
            sh = {sh[5:0], 2'b00};
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) slot(1'b0, 2'b00);
    endtask

    task automatic do_reset();
        bus.in_data = 3'b000;
        arst = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_data = 3'b100;
        arst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.out_data !== 24'h0) $display("FAIL reset_out_data got=%h exp=%h", bus.out_data, 24'h0); else n_pass++;
        n_checks++; if (bus.out_valid !== 3'b000) $display("FAIL reset_out_valid got=%b exp=000", bus.out_valid); else n_pass++;
        n_checks++; if (bus.sync_err !== 1'b0) $display("FAIL reset_sync_err got=%b exp=0", bus.sync_err); else n_pass++;
        n_checks++; if (bus.hdr_err !== 1'b0) $display("FAIL reset_hdr_err got=%b exp=0", bus.hdr_err); else n_pass++;
        n_checks++; if (bus.frame_cnt !== 16'h0) $display("FAIL reset_frame_cnt got=%h exp=0000", bus.frame_cnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
        bus.in_data = 3'b000;
        arst = 1'b1;
    endtask

    task automatic test_single_frame();
        send_byte(1'b1, 8'hA1);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy_in_pay got=%b exp=1", bus.busy); else n_pass++;
        send_byte(1'b0, 8'h5C);
        n_checks++; if (bus.out_data[15:8] !== 8'h5C) $display("FAIL single_ch1_data got=%h exp=5c", bus.out_data[15:8]); else n_pass++;
        n_checks++; if (bus.out_valid !== 3'b010) $display("FAIL single_valid got=%b exp=010", bus.out_valid); else n_pass++;
        n_checks++; if (bus.frame_cnt !== 16'd1) $display("FAIL single_frame_cnt got=%0d exp=1", bus.frame_cnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_done got=%b exp=0", bus.busy); else n_pass++;
        idle(1);
        n_checks++; if (bus.out_valid !== 3'b000) $display("FAIL single_valid_pulse got=%b exp=000", bus.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] hdrs [3];
        logic [7:0] pays [3];
        logic [2:0] vals [3];
        hdrs = '{8'hA0, 8'hA2, 8'hA1};
        pays = '{8'h11, 8'hEE, 8'h77};
        vals = '{3'b001, 3'b100, 3'b010};
        do_reset();
        for (int f = 0; f < 3; f++) begin
            send_byte(1'b1, hdrs[f]);
            n_checks++; if (bus.out_valid !== 3'b000) $display("FAIL b2b_valid_idle frame=%0d got=%b exp=000", f, bus.out_valid); else n_pass++;
            send_byte(1'b0, pays[f]);
            n_checks++; if (bus.out_valid !== vals[f]) $display("FAIL b2b_valid frame=%0d got=%b exp=%b", f, bus.out_valid, vals[f]); else n_pass++;
        end
        n_checks++; if (bus.out_data !== 24'hEE7711) $display("FAIL b2b_out_data got=%h exp=ee7711", bus.out_data); else n_pass++;
        n_checks++; if (bus.frame_cnt !== 16'd3) $display("FAIL b2b_frame_cnt got=%0d exp=3", bus.frame_cnt); else n_pass++;
    endtask

    task automatic test_bad_header();
        logic [7:0] bad [3];
        bad = '{8'hA3, 8'hB0, 8'hA4};
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b1, bad[i]);
            n_checks++; if (bus.hdr_err !== 1'b1) $display("FAIL badhdr_hdr_err hdr=%h got=%b exp=1", bad[i], bus.hdr_err); else n_pass++;
            n_checks++; if (bus.sync_err !== 1'b0) $display("FAIL badhdr_sync_err hdr=%h got=%b exp=0", bad[i], bus.sync_err); else n_pass++;
            n_checks++; if (bus.busy !== 1'b0) $display("FAIL badhdr_busy hdr=%h got=%b exp=0", bad[i], bus.busy); else n_pass++;
        end
        // Payload-looking slots after a rejected header must be ignored.
        send_byte(1'b0, 8'h99);
        n_checks++; if (bus.hdr_err !== 1'b0) $display("FAIL badhdr_pulse got=%b exp=0", bus.hdr_err); else n_pass++;
        n_checks++; if (bus.out_valid !== 3'b000) $display("FAIL badhdr_valid got=%b exp=000", bus.out_valid); else n_pass++;
        n_checks++; if (bus.frame_cnt !== 16'd3) $display("FAIL badhdr_frame_cnt got=%0d exp=3", bus.frame_cnt); else n_pass++;
        n_checks++; if (bus.out_data !== 24'hEE7711) $display("FAIL badhdr_out_data got=%h exp=ee7711", bus.out_data); else n_pass++;
    endtask

    task automatic test_sync_abort();
        send_byte(1'b1, 8'hA1);
        slot(1'b0, 2'b11);
        slot(1'b0, 2'b11);
        // Payload slot2 carries a marker: new frame A0/42 starts here.
        slot(1'b1, 2'b10);
        n_checks++; if (bus.sync_err !== 1'b1) $display("FAIL abort_pay_sync_err got=%b exp=1", bus.sync_err); else n_pass++;
        n_checks++; if (bus.hdr_err !== 1'b0) $display("FAIL abort_pay_hdr_err got=%b exp=0", bus.hdr_err); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL abort_pay_busy got=%b exp=1", bus.busy); else n_pass++;
        slot(1'b0, 2'b10);
        n_checks++; if (bus.sync_err !== 1'b0) $display("FAIL abort_pay_pulse got=%b exp=0", bus.sync_err); else n_pass++;
        slot(1'b0, 2'b00);
        slot(1'b0, 2'b00);
        send_byte(1'b0, 8'h42);
        n_checks++; if (bus.out_data !== 24'hEE7742) $display("FAIL abort_pay_out_data got=%h exp=ee7742", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_valid !== 3'b001) $display("FAIL abort_pay_valid got=%b exp=001", bus.out_valid); else n_pass++;
        n_checks++; if (bus.frame_cnt !== 16'd4) $display("FAIL abort_pay_frame_cnt got=%0d exp=4", bus.frame_cnt); else n_pass++;
        // Header B0 slots 0..2, then a marker in slot3 restarting as A2/33.
        slot(1'b1, 2'b10);
        slot(1'b0, 2'b11);
        slot(1'b0, 2'b00);
        slot(1'b1, 2'b10);
        n_checks++; if (bus.sync_err !== 1'b1) $display("FAIL abort_hdr_sync_err got=%b exp=1", bus.sync_err); else n_pass++;
        n_checks++; if (bus.hdr_err !== 1'b0) $display("FAIL abort_hdr_hdr_err got=%b exp=0", bus.hdr_err); else n_pass++;
        slot(1'b0, 2'b10);
        n_checks++; if (bus.hdr_err !== 1'b0) $display("FAIL abort_hdr_late_hdr_err got=%b exp=0", bus.hdr_err); else n_pass++;
        slot(1'b0, 2'b00);
        slot(1'b0, 2'b10);
        send_byte(1'b0, 8'h33);
        n_checks++; if (bus.out_data !== 24'h337742) $display("FAIL abort_hdr_out_data got=%h exp=337742", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_valid !== 3'b100) $display("FAIL abort_hdr_valid got=%b exp=100", bus.out_valid); else n_pass++;
        n_checks++; if (bus.frame_cnt !== 16'd5) $display("FAIL abort_hdr_frame_cnt got=%0d exp=5", bus.frame_cnt); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        send_byte(1'b1, 8'hA1);
        slot(1'b0, 2'b01);
        bus.in_data = {1'b0, 2'b10};
        #2;
        arst = 1'b0;
        #1;
        n_checks++; if (bus.out_data !== 24'h0) $display("FAIL midrst_out_data got=%h exp=000000", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_valid !== 3'b000) $display("FAIL midrst_valid got=%b exp=000", bus.out_valid); else n_pass++;
        n_checks++; if (bus.frame_cnt !== 16'h0) $display("FAIL midrst_frame_cnt got=%h exp=0000", bus.frame_cnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if ((bus.sync_err | bus.hdr_err) !== 1'b0) $display("FAIL midrst_errs got=%b%b exp=00", bus.sync_err, bus.hdr_err); else n_pass++;
        #1;
        arst = 1'b1;
        @(posedge clk);
        #1;
        slot(1'b0, 2'b11);
        slot(1'b0, 2'b11);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_no_resume got=%b exp=0", bus.busy); else n_pass++;
        send_byte(1'b1, 8'hA1);
        send_byte(1'b0, 8'h99);
        n_checks++; if (bus.out_data !== 24'h009900) $display("FAIL midrst_clean_data got=%h exp=009900", bus.out_data); else n_pass++;
        n_checks++; if (bus.out_valid !== 3'b010) $display("FAIL midrst_clean_valid got=%b exp=010", bus.out_valid); else n_pass++;
        n_checks++; if (bus.frame_cnt !== 16'd1) $display("FAIL midrst_clean_cnt got=%0d exp=1", bus.frame_cnt); else n_pass++;
    endtask

    task automatic test_cnt_wrap();
        idle(1);
        force dut.frame_cnt_q = 16'hFFFF;
        slot(1'b0, 2'b00);
        release dut.frame_cnt_q;
        n_checks++; if (bus.frame_cnt !== 16'hFFFF) $display("FAIL wrap_preload got=%h exp=ffff", bus.frame_cnt); else n_pass++;
        send_byte(1'b1, 8'hA0);
        send_byte(1'b0, 8'h5A);
        n_checks++; if (bus.frame_cnt !== 16'h0000) $display("FAIL wrap_frame_cnt got=%h exp=0000", bus.frame_cnt); else n_pass++;
        n_checks++; if (bus.out_valid !== 3'b001) $display("FAIL wrap_valid got=%b exp=001", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 24'h00995A) $display("FAIL wrap_out_data got=%h exp=00995a", bus.out_data); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        arst     = 1'b0;
        bus.in_data = 3'b000;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bad_header();
        test_sync_abort();
        test_reset_midframe();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
